// File: rtl/jb_mch_regs_pkg.sv
// Shared constants, AXI response codes, FSM states and address decode for the
// multi-channel control/status register bank.
package jb_mch_regs_pkg;

  localparam logic [31:0] VERSION     = 32'h0001_0000;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // Global register word selects (offset[3:2] below 0x010)
  localparam logic [1:0]  G_VERSION   = 2'd0;
  localparam logic [1:0]  G_SCRATCH   = 2'd1;
  localparam logic [1:0]  G_COMMIT    = 2'd2;
  localparam logic [1:0]  G_IRQ_STAT  = 2'd3;

  // Per-channel register word selects (offset[3:2] within a channel block)
  localparam logic [1:0]  C_SHADOW    = 2'd0;
  localparam logic [1:0]  C_STAT      = 2'd1;
  localparam logic [1:0]  C_EVT       = 2'd2;
  localparam logic [1:0]  C_MASK      = 2'd3;

  localparam logic [31:0] GLOBAL_SPAN = 32'h0000_0010;
  localparam logic [31:0] CHAN_BASE   = 32'h0000_0100;
  localparam logic [31:0] CHAN_STRIDE = 32'h0000_0010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_RESP = 2'd1,
    RD_RESP = 2'd2
  } axi_state_t;

  typedef struct packed {
    logic       valid;
    logic       is_chan;
    logic [4:0] ch;
    logic [1:0] sel;
  } dec_t;

  function automatic dec_t decode_addr(input logic [31:0] addr, input int unsigned num_ch);
    dec_t        d;
    logic [31:0] rel;
    d     = '0;
    rel   = addr - CHAN_BASE;
    d.sel = addr[3:2];
    if (addr < GLOBAL_SPAN) begin
      d.valid = 1'b1;
    end else if ((addr >= CHAN_BASE) && (addr < (CHAN_BASE + num_ch * CHAN_STRIDE))) begin
      d.valid   = 1'b1;
      d.is_chan = 1'b1;
      d.ch      = rel[8:4];
    end
    return d;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/jb_axi4_lite_if.sv
// AXI4-lite signal bundle with slave and master views.
interface jb_axi4_lite_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/jb_mch_chan_regs.sv
// One channel: shadowed control, committed control, sticky W1C events with
// mask, read mux and the channel's interrupt contribution.
module jb_mch_chan_regs import jb_mch_regs_pkg::*; #(
  parameter int unsigned       CTRL_W   = 16,
  parameter int unsigned       STAT_W   = 16,
  parameter int unsigned       EVT_W    = 8,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [1:0]        wr_sel,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_strb,
  input  logic              commit,
  input  logic [STAT_W-1:0] stat,
  input  logic [EVT_W-1:0]  evt,
  input  logic [1:0]        rd_sel,
  output logic [31:0]       rd_data,
  output logic [CTRL_W-1:0] ctrl,
  output logic              irq
);

  logic [31:0]       bmask;
  logic [31:0]       unused_wr;
  logic [CTRL_W-1:0] shadow;
  logic [EVT_W-1:0]  evt_q;
  logic [EVT_W-1:0]  mask_q;
  logic [EVT_W-1:0]  clr;

  assign bmask     = strb_mask(wr_strb);
  assign unused_wr = wr_data & bmask;

  always_comb begin
    clr = '0;
    if (wr_en && (wr_sel == C_EVT)) begin
      clr = wr_data[EVT_W-1:0] & bmask[EVT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= CTRL_RST;
      ctrl   <= CTRL_RST;
      evt_q  <= '0;
      mask_q <= '0;
    end else begin
      if (wr_en && (wr_sel == C_SHADOW)) begin
        shadow <= (shadow & ~bmask[CTRL_W-1:0]) | (wr_data[CTRL_W-1:0] & bmask[CTRL_W-1:0]);
      end
      if (wr_en && (wr_sel == C_MASK)) begin
        mask_q <= (mask_q & ~bmask[EVT_W-1:0]) | (wr_data[EVT_W-1:0] & bmask[EVT_W-1:0]);
      end
      if (commit) begin
        ctrl <= shadow;
      end
      // New pulses are ORed in after the clear so a coincident set wins
      evt_q <= (evt_q & ~clr) | evt;
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_sel)
      C_SHADOW: rd_data = 32'(shadow);
      C_STAT:   rd_data = 32'(stat);
      C_EVT:    rd_data = 32'(evt_q);
      default:  rd_data = 32'(mask_q);
    endcase
  end

  assign irq = |(evt_q & mask_q);

endmodule

// File: rtl/jb_mch_ctrl_regs.sv
// Multi-channel control/status register bank with AXI4-lite slave: single
// outstanding transaction FSM, global registers, read mux and interrupt OR.
module jb_mch_ctrl_regs import jb_mch_regs_pkg::*; #(
  parameter int unsigned       AXI_ADDR_WIDTH = 13,
  parameter int unsigned       AXI_DATA_WIDTH = 32,
  parameter int unsigned       NUM_CH         = 4,
  parameter int unsigned       CTRL_W         = 16,
  parameter int unsigned       STAT_W         = 16,
  parameter int unsigned       EVT_W          = 8,
  parameter logic [CTRL_W-1:0] CTRL_RST       = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  jb_axi4_lite_if.slave            IFP_axi4_lite,
  output logic [NUM_CH*CTRL_W-1:0] ctrl_o,
  input  logic [NUM_CH*STAT_W-1:0] stat_i,
  input  logic [NUM_CH*EVT_W-1:0]  evt_i,
  output logic                     commit_o,
  output logic                     irq_o
);

  logic [AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [AXI_ADDR_WIDTH-1:0]   araddr;
  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                        awvalid;
  logic                        wvalid;
  logic                        arvalid;
  logic                        bready;
  logic                        rready;

  axi_state_t  state;
  axi_state_t  state_nx;
  logic        awready;
  logic        wready;
  logic        arready;
  logic        bvalid;
  logic        rvalid;
  logic [1:0]  bresp;
  logic [1:0]  rresp;
  logic [31:0] rdata;

  dec_t        wdec;
  dec_t        rdec;
  logic        wr_fire;
  logic        rd_fire;
  logic        commit_hit;
  logic [31:0] wmask;
  logic [31:0] scratch;
  logic [31:0] rd_mux;

  logic [NUM_CH-1:0] chan_we;
  logic [NUM_CH-1:0] irq_bits;
  logic [31:0]       ch_rd [NUM_CH];

  assign awaddr  = IFP_axi4_lite.awaddr;
  assign araddr  = IFP_axi4_lite.araddr;
  assign wdata   = IFP_axi4_lite.wdata;
  assign wstrb   = IFP_axi4_lite.wstrb;
  assign awvalid = IFP_axi4_lite.awvalid;
  assign wvalid  = IFP_axi4_lite.wvalid;
  assign arvalid = IFP_axi4_lite.arvalid;
  assign bready  = IFP_axi4_lite.bready;
  assign rready  = IFP_axi4_lite.rready;

  assign IFP_axi4_lite.awready = awready;
  assign IFP_axi4_lite.wready  = wready;
  assign IFP_axi4_lite.arready = arready;
  assign IFP_axi4_lite.bvalid  = bvalid;
  assign IFP_axi4_lite.bresp   = bresp;
  assign IFP_axi4_lite.rvalid  = rvalid;
  assign IFP_axi4_lite.rresp   = rresp;
  assign IFP_axi4_lite.rdata   = rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // A write with either half pending blocks the read so AW/W always win
  always_comb begin
    state_nx = state;
    awready  = 1'b0;
    wready   = 1'b0;
    arready  = 1'b0;
    case (state)
      IDLE: begin
        if (awvalid && wvalid) begin
          awready  = 1'b1;
          wready   = 1'b1;
          state_nx = WR_RESP;
        end else if (arvalid && !awvalid && !wvalid) begin
          arready  = 1'b1;
          state_nx = RD_RESP;
        end
      end
      WR_RESP: if (bready) state_nx = IDLE;
      RD_RESP: if (rready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bvalid  = (state == WR_RESP);
  assign rvalid  = (state == RD_RESP);
  assign wr_fire = awready;
  assign rd_fire = arready;

  assign wdec  = decode_addr(32'(awaddr), NUM_CH);
  assign rdec  = decode_addr(32'(araddr), NUM_CH);
  assign wmask = strb_mask(wstrb);

  assign commit_hit = wr_fire && wdec.valid && !wdec.is_chan &&
                      (wdec.sel == G_COMMIT) && wstrb[0] && wdata[0];

  always_comb begin
    rd_mux = '0;
    if (!rdec.is_chan) begin
      case (rdec.sel)
        G_VERSION:  rd_mux = VERSION;
        G_SCRATCH:  rd_mux = scratch;
        G_IRQ_STAT: rd_mux = 32'(irq_bits);
        default:    rd_mux = '0;
      endcase
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (rdec.ch == 5'(c)) rd_mux = ch_rd[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch  <= '0;
      bresp    <= RESP_OKAY;
      rresp    <= RESP_OKAY;
      rdata    <= '0;
      commit_o <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      commit_o <= commit_hit;
      irq_o    <= |irq_bits;
      if (wr_fire) begin
        bresp <= wdec.valid ? RESP_OKAY : RESP_SLVERR;
        if (wdec.valid && !wdec.is_chan && (wdec.sel == G_SCRATCH)) begin
          scratch <= (scratch & ~wmask) | (wdata & wmask);
        end
      end
      if (rd_fire) begin
        rresp <= rdec.valid ? RESP_OKAY : RESP_SLVERR;
        rdata <= rdec.valid ? rd_mux : '0;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign chan_we[c] = wr_fire && wdec.valid && wdec.is_chan && (wdec.ch == 5'(c));

    jb_mch_chan_regs #(
      .CTRL_W   (CTRL_W),
      .STAT_W   (STAT_W),
      .EVT_W    (EVT_W),
      .CTRL_RST (CTRL_RST)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (chan_we[c]),
      .wr_sel  (wdec.sel),
      .wr_data (wdata),
      .wr_strb (wstrb),
      .commit  (commit_hit),
      .stat    (stat_i[c*STAT_W +: STAT_W]),
      .evt     (evt_i[c*EVT_W +: EVT_W]),
      .rd_sel  (rdec.sel),
      .rd_data (ch_rd[c]),
      .ctrl    (ctrl_o[c*CTRL_W +: CTRL_W]),
      .irq     (irq_bits[c])
    );
  end

endmodule
